// File: rtl/riscv_data_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : riscv_data_memory                                          |
// | Description : Byte-addressed word memory with a fetch port and a RISC-V  |
// |               load/store port; clears itself to zero after every reset.  |
// | Option      : MEMORY_MISALIGN_TRAP_EN (trap misaligned accesses)         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module riscv_data_memory #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  input  logic [31:0] data_address,
  input  logic        data_read_en,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_data,
  output logic [31:0] data_read_data,
  output logic        data_valid,
  output logic        fault,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_clr_cnt;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_ready;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_f3_ld_ok;
  logic            w_f3_st_ok;
  logic            w_size_h;
  logic            w_size_w;
  logic            w_misaligned;
  logic            w_mis_fault;
  logic [1:0]      w_lane;
  logic            w_ld_bad;
  logic            w_st_bad;
  logic            w_we;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [AW-1:0]   w_d_idx;
  logic [AW-1:0]   w_f_idx;
  logic [31:0]     w_word;
  logic [31:0]     w_shift;
  logic [31:0]     w_ld_result;
  logic            w_unused;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (r_clr_cnt == AW'(DEPTH_WORDS - 1)) w_state_next = READY;
      READY:   w_state_next = READY;
      default: w_state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  assign busy       = (r_state == CLEAR);
  assign w_ready    = (r_state == READY);
  assign w_is_store = w_ready & write_mem;
  assign w_is_load  = w_ready & data_read_en & ~write_mem;

  always_comb begin
    w_f3_ld_ok = 1'b0;
    w_f3_st_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: begin
        w_f3_ld_ok = 1'b1;
        w_f3_st_ok = 1'b1;
      end
      3'b100, 3'b101: w_f3_ld_ok = 1'b1;
      default: ;
    endcase
  end

  assign w_size_h     = (funct3[1:0] == 2'b01);
  assign w_size_w     = (funct3[1:0] == 2'b10);
  assign w_misaligned = (w_size_h & data_address[0]) | (w_size_w & (|data_address[1:0]));

`ifdef MEMORY_MISALIGN_TRAP_EN
  assign w_mis_fault = w_misaligned;
  assign w_lane      = data_address[1:0];
`else
  // Misaligned halfword/word accesses snap down to their natural boundary
  assign w_mis_fault = 1'b0;
  assign w_lane      = w_size_w ? 2'b00 :
                       w_size_h ? {data_address[1], 1'b0} : data_address[1:0];
`endif

  assign w_ld_bad = ~w_f3_ld_ok | w_mis_fault;
  assign w_st_bad = ~w_f3_st_ok | w_mis_fault;
  assign w_we     = w_is_store & ~w_st_bad;
  assign w_d_idx  = data_address[AW+1:2];
  assign w_f_idx  = read_address[AW+1:2];
  assign w_unused = ^{read_address[31:AW+2], read_address[1:0],
                      data_address[31:AW+2], w_misaligned};

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = write_data;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{write_data[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_lane;
        w_wdata = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_word  = r_mem[w_d_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};

  always_comb begin
    w_ld_result = '0;
    case (funct3)
      3'b000:  w_ld_result = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ld_result = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b010:  w_ld_result = w_word;
      3'b100:  w_ld_result = {24'd0, w_shift[7:0]};
      3'b101:  w_ld_result = {16'd0, w_shift[15:0]};
      default: w_ld_result = '0;
    endcase
    if (w_ld_bad) w_ld_result = '0;
  end

  // Reads in the other processes see pre-write contents on a same-word collision
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_d_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data      <= '0;
      data_read_data <= '0;
      data_valid     <= 1'b0;
      fault          <= 1'b0;
    end else begin
      read_data  <= w_ready ? r_mem[w_f_idx] : '0;
      data_valid <= w_is_load;
      fault      <= (w_is_load & w_ld_bad) | (w_is_store & w_st_bad);
      if (w_is_load) data_read_data <= w_ld_result;
    end
  end

endmodule
`default_nettype wire
